mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 Clock and reset SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 E_start  input  1  E-stage MDU instruction valid this cycle.
REQ-007 E_md_op  input  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-15 reserved.
REQ-008 E_rs_data  input  32  forwarded rs operand (dividend / multiplicand / MT source).
REQ-009 E_rt_data  input  32  forwarded rt operand (divisor / multiplier).
REQ-010 D_is_md  input  1  D-stage instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-011 hi  output  32  architectural HI register.
REQ-012 lo  output  32  architectural LO register.
REQ-013 busy  output  1  registered; high while an operation is in flight.
REQ-014 stall_md  output  1  combinational stall request to the pipeline hazard logic.

Function
REQ-015 Two states, IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-016 IDLE, E_start=1, op 1-4: operands and op latch at edge; counter loads MULT_CYCLES or DIV_CYCLES; go RUN.
REQ-017 RUN: counter decrements each edge; on the edge where counter==1, result commits to hi/lo and state returns to IDLE in the same edge.
REQ-018 Start at edge N: busy high for exactly LAT cycles (edges N..N+LAT-1 outputs); new hi/lo visible after edge N+LAT, same edge busy falls.
REQ-019 MULT: {hi,lo} = signed 64-bit product; MULTU: unsigned 64-bit product.
REQ-020 DIV: lo = signed quotient truncated toward zero, hi = remainder carrying sign of dividend; DIVU: unsigned quotient/remainder.
REQ-021 Divisor zero (DIV/DIVU): full DIV_CYCLES busy, hi/lo unchanged at completion.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-023 IDLE, E_start=1, MTHI: hi<=E_rs_data at that edge, lo unchanged, no busy; MTLO symmetric on lo.
REQ-024 E_start=1 with op NONE or reserved: no state change.
REQ-025 E_start=1 while RUN: ignored entirely (pipeline guarantees it does not occur; must not corrupt in-flight op).
REQ-026 Latched operands used for result; changes on E_rs_data/E_rt_data during RUN SHALL not affect result.
REQ-027 stall_md = D_is_md && (busy || (E_start && E_md_op in 1..4)).
REQ-028 stall_md SHALL be 0 on the cycle after busy falls unless a new op 1-4 starts in E.
REQ-029 hi/lo hold value in all cases not listed above.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE, counter 0, busy 0, hi 0, lo 0, latched operands 0.
REQ-031 Reset asserted mid-RUN aborts the op; no commit after reset release; first edge after release behaves as IDLE.
REQ-032 stall_md SHALL be 0 during reset regardless of D_is_md (busy 0 and E_start forced ignored).

Verification
REQ-033 MULT rs=0xFFFFFFFD, rt=4 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF4.
REQ-034 DIVU 7/2 -> busy 10 cycles, lo=3, hi=1; DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 MTHI 0x12345678 then DIV x/0 -> busy 10 cycles, hi remains 0x12345678, lo unchanged.
REQ-036 MULTU with D_is_md=1 held -> stall_md=1 on start cycle and all 5 busy cycles, 0 the cycle after.
REQ-037 DIV started, reset_n pulsed low at busy cycle 4 -> busy=0, hi=lo=0 immediately; no later commit.
REQ-038 E_start MULT during RUN of DIV, operands changed mid-run -> DIV result correct, issued MULT ignored.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller holding the architectural HI/LO
// registers. Long operations (MULT/MULTU/DIV/DIVU) latch their operands,
// hold busy for a fixed number of cycles, and commit to HI/LO on the final
// busy edge. MTHI/MTLO write in a single edge without going busy.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   E_start    E-stage MDU instruction valid
//   E_md_op    operation code (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   E_rs_data  rs operand (dividend / multiplicand / MT source)
//   E_rt_data  rt operand (divisor / multiplier)
//   D_is_md    D-stage instruction touches the MDU
//   hi, lo     architectural HI / LO registers
//   busy       high while a long operation is in flight
//   stall_md   combinational stall request to hazard logic
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        E_start,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_is_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PROD_W     = 2 * DATA_W;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [3:0]        op_q;
  logic [3:0]        op_nxt;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] b_nxt;
  logic [DATA_W-1:0] hi_nxt;
  logic [DATA_W-1:0] lo_nxt;

  logic start_long;
  logic start_mult;

  // Decode of the incoming E-stage request.
  always_comb begin
    start_mult = E_start && ((E_md_op == OP_MULT) || (E_md_op == OP_MULTU));
    start_long = E_start && ((E_md_op == OP_MULT) || (E_md_op == OP_MULTU) ||
                             (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU));
  end

  // Datapath on latched operands; only sampled on the commit edge.
  logic              op_signed;
  logic              op_is_mult;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] product;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] quo_mag;
  logic [DATA_W-1:0] rem_mag;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;

  always_comb begin
    op_signed  = (op_q == OP_MULT) || (op_q == OP_DIV);
    op_is_mult = (op_q == OP_MULT) || (op_q == OP_MULTU);

    // Sign- or zero-extend to 64 bits; the low 64 product bits are then exact
    // for both signed and unsigned operands.
    a_ext   = {{DATA_W{op_signed & a_q[DATA_W-1]}}, a_q};
    b_ext   = {{DATA_W{op_signed & b_q[DATA_W-1]}}, b_q};
    product = a_ext * b_ext;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    a_neg   = op_signed & a_q[DATA_W-1];
    b_neg   = op_signed & b_q[DATA_W-1];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    quo_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
    rem_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);
    quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem     = a_neg ? -rem_mag : rem_mag;
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      op_q  <= op_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_long) state_nxt = RUN;
      RUN:  if (count == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    count_nxt = count;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start_long) begin
          op_nxt    = E_md_op;
          a_nxt     = E_rs_data;
          b_nxt     = E_rt_data;
          count_nxt = start_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (E_start && (E_md_op == OP_MTHI)) begin
          hi_nxt = E_rs_data;
        end else if (E_start && (E_md_op == OP_MTLO)) begin
          lo_nxt = E_rs_data;
        end
      end
      RUN: begin
        // New requests are ignored here; the in-flight op owns the unit.
        count_nxt = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          if (op_is_mult) begin
            hi_nxt = product[PROD_W-1:DATA_W];
            lo_nxt = product[DATA_W-1:0];
          end else if (b_q != '0) begin
            hi_nxt = rem;
            lo_nxt = quo;
          end
        end
      end
      default: count_nxt = '0;
    endcase
  end

  assign busy = (state == RUN);

  // Stall while busy or while a long op is entering; never while in reset.
  assign stall_md = reset_n && D_is_md && (busy || start_long);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: self-checking bench for mdu_ctrl with a reference model of
// HI/LO computed with 64-bit integer arithmetic.
module tb_mdu_ctrl;

  localparam int unsigned MULT_CYCLES = 5;
  localparam int unsigned DIV_CYCLES  = 10;

  logic        clk;
  logic        reset_n;
  logic        E_start;
  logic [3:0]  E_md_op;
  logic [31:0] E_rs_data;
  logic [31:0] E_rt_data;
  logic        D_is_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_ctrl #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .E_start  (E_start),
    .E_md_op  (E_md_op),
    .E_rs_data(E_rs_data),
    .E_rt_data(E_rt_data),
    .D_is_md  (D_is_md),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall_md (stall_md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return int'(MULT_CYCLES);
      4'd3, 4'd4: return int'(DIV_CYCLES);
      default:    return 0;
    endcase
  endfunction

  // Architectural effect of one accepted instruction on HI/LO.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
      4'd2: begin p = {32'b0, a} * {32'b0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      4'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        exp_lo = q[31:0]; exp_hi = r[31:0];
      end
      4'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      4'd5: exp_hi = a;
      4'd6: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue one instruction (called at posedge+1) and count busy cycles.
  // Operands are scrambled right after the start edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    E_start = 1'b1; E_md_op = op; E_rs_data = a; E_rt_data = b;
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = 4'd0; E_rs_data = $urandom; E_rt_data = $urandom;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; E_start = 1'b0; E_md_op = '0; E_rs_data = '0; E_rt_data = '0;
    D_is_md = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_md); end
    reset_n = 1'b1; D_is_md = 1'b0;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed();
    int n;
    run_op(4'd1, 32'hFFFFFFFD, 32'd4, n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_lat: got %0d expected 5", n); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF4) begin errors++;
      $display("FAIL mult_neg: got %h_%h expected ffffffff_fffffff4", hi, lo); end
    run_op(4'd4, 32'd7, 32'd2, n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu_lat: got %0d expected 10", n); end
    checks++; if (hi !== 32'd1 || lo !== 32'd3) begin errors++;
      $display("FAIL divu_7_2: got %h_%h expected 00000001_00000003", hi, lo); end
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++;
      $display("FAIL div_neg: got %h_%h expected ffffffff_fffffffd", hi, lo); end
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    checks++; if (hi !== 32'h0 || lo !== 32'h80000000) begin errors++;
      $display("FAIL div_ovf: got %h_%h expected 00000000_80000000", hi, lo); end
    exp_hi = hi === 32'h0 ? 32'h0 : 32'h0; exp_lo = 32'h80000000;
  endtask

  task automatic test_div_zero();
    int n;
    run_op(4'd6, 32'hCAFEF00D, 32'h0, n);
    run_op(4'd5, 32'h12345678, 32'h0, n);
    checks++; if (n != 0 || hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin errors++;
      $display("FAIL mt_write: got busy=%0d %h_%h expected 0 12345678_cafef00d", n, hi, lo); end
    run_op(4'd3, 32'h00001234, 32'h0, n);
    checks++; if (n != 10) begin errors++; $display("FAIL div0_lat: got %0d expected 10", n); end
    checks++; if (hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin errors++;
      $display("FAIL div0_hold: got %h_%h expected 12345678_cafef00d", hi, lo); end
    run_op(4'd4, 32'hFFFFFFFF, 32'h0, n);
    checks++; if (n != 10 || hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin errors++;
      $display("FAIL divu0_hold: got busy=%0d %h_%h expected 10 12345678_cafef00d", n, hi, lo); end
    exp_hi = 32'h12345678; exp_lo = 32'hCAFEF00D;
  endtask

  task automatic test_stall();
    int n, ones;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    D_is_md = 1'b1;
    E_start = 1'b1; E_md_op = 4'd2; E_rs_data = a; E_rt_data = b;
    #1;
    checks++; if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_start: got %b expected 1", stall_md); end
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = 4'd0;
    n = 0; ones = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (stall_md === 1'b1) ones++;
      @(posedge clk); #1;
    end
    model_apply(4'd2, a, b);
    checks++; if (n != 5 || ones != 5) begin errors++;
      $display("FAIL stall_busy: got busy=%0d stall=%0d expected 5 5", n, ones); end
    checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL stall_after: got %b expected 0", stall_md); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL multu_res: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
    // A non-long op in E must not stall.
    E_start = 1'b1; E_md_op = 4'd5; #1;
    checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL stall_mthi: got %b expected 0", stall_md); end
    E_start = 1'b0; E_md_op = 4'd0; D_is_md = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_in_run();
    int n;
    logic [31:0] a, b;
    a = $urandom; b = $urandom_range(1, 1000);
    model_apply(4'd3, a, b);
    E_start = 1'b1; E_md_op = 4'd3; E_rs_data = a; E_rt_data = b;
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 3) begin E_start = 1'b1; E_md_op = 4'd1; end
      E_rs_data = $urandom; E_rt_data = $urandom;
      if (n == 6) begin E_start = 1'b0; E_md_op = 4'd0; end
      @(posedge clk); #1;
    end
    checks++; if (n != 10) begin errors++; $display("FAIL ign_lat: got %0d expected 10", n); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
      $display("FAIL ign_res: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_nostart: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midrun();
    int n, late;
    run_op(4'd5, 32'hA5A5A5A5, 32'h0, n);
    run_op(4'd6, 32'h5A5A5A5A, 32'h0, n);
    E_start = 1'b1; E_md_op = 4'd3; E_rs_data = 32'd1000; E_rt_data = 32'd7;
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = 4'd0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
    D_is_md = 1'b1; E_start = 1'b1; E_md_op = 4'd1;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++;
      $display("FAIL rst_async: got busy=%b %h_%h expected 0 00000000_00000000", busy, hi, lo); end
    checks++; if (stall_md !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall_md); end
    @(posedge clk); #1;
    E_start = 1'b0; E_md_op = 4'd0; D_is_md = 1'b0;
    reset_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    late = 0;
    repeat (12) begin @(posedge clk); #1; if (busy === 1'b1) late++; end
    checks++; if (late != 0 || hi !== 32'h0 || lo !== 32'h0) begin errors++;
      $display("FAIL rst_nocommit: got busy_cycles=%0d %h_%h expected 0 00000000_00000000", late, hi, lo); end
  endtask

  task automatic test_random();
    int n;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 6));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      run_op(op, a, b, n);
      model_apply(op, a, b);
      checks++; if (n != exp_lat(op)) begin errors++;
        $display("FAIL rnd_lat[%0d] op=%0d: got %0d expected %0d", i, op, n, exp_lat(op)); end
      checks++; if (hi !== exp_hi || lo !== exp_lo) begin errors++;
        $display("FAIL rnd_res[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h",
                 i, op, a, b, hi, lo, exp_hi, exp_lo); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_stall();
    test_ignore_in_run();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
